fft_stage_sequencer: RTL and testbench

FFT_STAGE_SEQUENCER -- requirements
Module: fft_stage_sequencer

---
 rtl/fft_pkg.sv | 22 ++
 rtl/fft_delay_line.sv | 30 +++
 rtl/fft_stage_sequencer.sv | 104 ++++++++++
 tb/tb_fft_stage_sequencer.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared definitions for the FFT stage sequencer: state encoding, size defaults
// and the butterfly-count width derived from the stage count.
package fft_pkg;

    localparam int unsigned NUMSTAGES_DEF = 8;
    localparam int unsigned NUMPASSES_DEF = 5;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } seq_state_t;

    // Each pass touches 2^(NUMSTAGES-2) butterflies, so the index needs NUMSTAGES-2 bits.
    function automatic int unsigned count_width(input int unsigned stages);
        return stages - 2;
    endfunction

    localparam int unsigned COUNT_W_DEF = count_width(NUMSTAGES_DEF);

endpackage

// File: rtl/fft_delay_line.sv
// Fixed-depth register delay line; asynchronous reset clears every stage so
// in-flight words are discarded.
module fft_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe[i] <= '0;
            end
        end else begin
            pipe[0] <= din;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                pipe[i] <= pipe[i-1];
            end
        end
    end

    assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_stage_sequencer.sv
// Pass sequencer for an in-place radix-2 FFT: issues butterfly reads per pass,
// drains the butterfly pipeline, swaps banks and counts passes until done.
module fft_stage_sequencer
    import fft_pkg::*;
#(
    parameter int unsigned NUMSTAGES = NUMSTAGES_DEF,
    parameter int unsigned NUMPASSES = NUMPASSES_DEF,
    parameter int unsigned BFLY_LAT  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 rd_en,
    output logic [NUMSTAGES-3:0] rd_count,
    output logic                 wr_en,
    output logic [NUMSTAGES-3:0] wr_count,
    output logic [2:0]           stage_num,
    output logic                 bank_sel
);

    localparam int unsigned CW         = count_width(NUMSTAGES);
    localparam logic [3:0]  LAST_DRAIN = 4'(BFLY_LAT - 1);
    localparam logic [2:0]  LAST_PASS  = 3'(NUMPASSES - 1);
    localparam logic [CW-1:0] LAST_RD  = '1;

    seq_state_t state;
    logic [3:0] drain_cnt;
    logic [CW:0] wr_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            drain_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_en     <= 1'b0;
            rd_count  <= '0;
            stage_num <= '0;
            bank_sel  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    rd_count  <= '0;
                    stage_num <= '0;
                    bank_sel  <= 1'b0;
                    done      <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        rd_en <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Wraps to zero after the last butterfly, ready for the next pass.
                    rd_count <= rd_count + 1'b1;
                    if (rd_count == LAST_RD) begin
                        state     <= S_DRAIN;
                        rd_en     <= 1'b0;
                        drain_cnt <= '0;
                    end
                end
                S_DRAIN: begin
                    if (drain_cnt == LAST_DRAIN) begin
                        if (stage_num < LAST_PASS) begin
                            state     <= S_RUN;
                            stage_num <= stage_num + 3'd1;
                            bank_sel  <= ~bank_sel;
                            rd_en     <= 1'b1;
                        end else begin
                            state <= S_DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        drain_cnt <= drain_cnt + 4'd1;
                    end
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    done      <= 1'b0;
                    busy      <= 1'b0;
                    stage_num <= '0;
                    bank_sel  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    fft_delay_line #(
        .WIDTH(CW + 1),
        .DEPTH(BFLY_LAT)
    ) u_delay (
        .clk  (clk),
        .rst_n(rst_n),
        .din  ({rd_en, rd_count}),
        .dout (wr_word)
    );

    assign wr_en    = wr_word[CW];
    assign wr_count = wr_word[CW-1:0];

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Directed bench: default-size sequencer (latency 3, 5 passes) and a small
// instance (latency 1, 1 pass) checked cycle by cycle against expected timing.
module tb_fft_stage_sequencer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start_a, start_b;
    logic       busy_a, done_a, rd_en_a, wr_en_a, bank_a;
    logic [5:0] rdc_a, wrc_a;
    logic [2:0] stage_a;
    logic       busy_b, done_b, rd_en_b, wr_en_b, bank_b;
    logic [5:0] rdc_b, wrc_b;
    logic [2:0] stage_b;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    fft_stage_sequencer u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a), .rd_count(rdc_a),
        .wr_en(wr_en_a), .wr_count(wrc_a), .stage_num(stage_a), .bank_sel(bank_a)
    );

    fft_stage_sequencer #(
        .NUMPASSES(1),
        .BFLY_LAT (1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b), .rd_count(rdc_b),
        .wr_en(wr_en_b), .wr_count(wrc_b), .stage_num(stage_b), .bank_sel(bank_b)
    );

    task automatic check(input string tag, input int rel, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s rel=%0d observed=%0d expected=%0d", tag, rel, obs, exp);
        end
    endtask

    // Expected outputs rel cycles after the first RUN cycle; past DONE everything is 0.
    task automatic check_cycle(input bit sel, input int rel, input int lat, input int npass);
        int plen = 64 + lat;
        int p, o;
        int e_rd = 0, e_rdc = 0, e_wr = 0, e_wrc = 0;
        int e_stage = 0, e_bank = 0, e_busy = 0, e_done = 0;
        if (rel < npass * plen) begin
            p       = rel / plen;
            o       = rel % plen;
            e_busy  = 1;
            e_rd    = (o < 64) ? 1 : 0;
            e_rdc   = (o < 64) ? o : 0;
            e_wr    = (o >= lat) ? 1 : 0;
            e_wrc   = (o >= lat) ? o - lat : 0;
            e_stage = p;
            e_bank  = p % 2;
        end else if (rel == npass * plen) begin
            e_busy  = 1;
            e_done  = 1;
            e_stage = npass - 1;
            e_bank  = (npass - 1) % 2;
        end
        if (!sel) begin
            check("a_busy", rel, 32'(busy_a), 32'(e_busy));
            check("a_done", rel, 32'(done_a), 32'(e_done));
            check("a_rd_en", rel, 32'(rd_en_a), 32'(e_rd));
            check("a_rd_count", rel, 32'(rdc_a), 32'(e_rdc));
            check("a_wr_en", rel, 32'(wr_en_a), 32'(e_wr));
            check("a_wr_count", rel, 32'(wrc_a), 32'(e_wrc));
            check("a_stage", rel, 32'(stage_a), 32'(e_stage));
            check("a_bank", rel, 32'(bank_a), 32'(e_bank));
        end else begin
            check("b_busy", rel, 32'(busy_b), 32'(e_busy));
            check("b_done", rel, 32'(done_b), 32'(e_done));
            check("b_rd_en", rel, 32'(rd_en_b), 32'(e_rd));
            check("b_rd_count", rel, 32'(rdc_b), 32'(e_rdc));
            check("b_wr_en", rel, 32'(wr_en_b), 32'(e_wr));
            check("b_wr_count", rel, 32'(wrc_b), 32'(e_wrc));
            check("b_stage", rel, 32'(stage_b), 32'(e_stage));
            check("b_bank", rel, 32'(bank_b), 32'(e_bank));
        end
    endtask

    task automatic run_cycles(input bit sel, input int lat, input int npass, input int first,
                              input int last, input int p1, input int p2, input bit hold);
        for (int r = first; r <= last; r++) begin
            @(negedge clk);
            check_cycle(sel, r, lat, npass);
            if (sel) start_b = hold || cyc == p1 || cyc == p2;
            else     start_a = hold || cyc == p1 || cyc == p2;
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check_cycle(1'b0, 100000, 3, 5);
        check_cycle(1'b1, 100000, 1, 1);
        while (cyc != 3) @(negedge clk);
        rst_n = 1'b1;

        // Single transform started in cycle 10, with start pulses at 20 and 200 ignored.
        while (cyc != 10) @(negedge clk);
        start_a = 1'b1;
        run_cycles(1'b0, 3, 5, 0, 337, 20, 200, 1'b0);

        // Reset in pass 2 mid-RUN, then a fresh full transform.
        @(negedge clk);
        start_a = 1'b1;
        run_cycles(1'b0, 3, 5, 0, 139, -1, -1, 1'b0);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check_cycle(1'b0, 100000, 3, 5);
        @(negedge clk);
        rst_n = 1'b1;
        run_cycles(1'b0, 3, 5, 100000, 100019, -1, -1, 1'b0);
        start_a = 1'b1;
        run_cycles(1'b0, 3, 5, 0, 337, -1, -1, 1'b0);

        // Start held high: back-to-back transforms with a single IDLE cycle between.
        start_a = 1'b1;
        run_cycles(1'b0, 3, 5, 0, 336, -1, -1, 1'b1);
        run_cycles(1'b0, 3, 5, 0, 337, -1, -1, 1'b0);

        // Minimal configuration: latency 1, one pass.
        start_b = 1'b1;
        run_cycles(1'b1, 1, 1, 0, 67, -1, -1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
